// File: rtl/bias_stream_ctrl.sv
// bias_stream_ctrl: streams the bias ROM, all KERNELS words per pixel, PIXELS
// times per frame, into an AP-FIFO style output stream. ROM reads are only
// issued when the 2-entry output buffer is guaranteed room for the returning
// word, so backpressure never loses or duplicates data.
//
// state | meaning
// IDLE  | waiting for ap_start; ap_idle high
// RUN   | issuing ROM reads whenever a buffer credit is available
// DRAIN | every read issued; emptying the buffer, ap_done after the last write
module bias_stream_ctrl #(
    parameter int KERNELS    = 16,
    parameter int PIXELS     = 64,
    parameter int DATA_WIDTH = 16,
    localparam int AW = (KERNELS > 1) ? $clog2(KERNELS) : 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic [AW-1:0]         rom_address,
    output logic                  rom_ce,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] output_V_din,
    input  logic                  output_V_full_n,
    output logic                  output_V_write
);

    localparam int PW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [AW-1:0] KERN_LAST = AW'(KERNELS - 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(PIXELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         kern_q, kern_d;
    logic [PW-1:0]         pix_q, pix_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                  done_q, done_d;

    logic       pop;
    logic       push;
    logic [2:0] level;
    logic       issue;

    // Credit accounting: words held plus the word returning from the ROM,
    // less the word leaving this cycle, must leave room for one more read.
    always_comb begin
        pop   = (occ_q != 2'd0) && output_V_full_n;
        push  = inflight_q;
        level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue = (state_q == ST_RUN) && (level <= 3'd1);
    end

    // Next-state logic: sequencing counters and frame completion.
    always_comb begin
        state_d    = state_q;
        kern_d     = kern_q;
        pix_d      = pix_q;
        done_d     = 1'b0;
        inflight_d = issue;
        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    state_d = ST_RUN;
                    kern_d  = '0;
                    pix_d   = '0;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    if (kern_q == KERN_LAST) begin
                        kern_d = '0;
                        if (pix_q == PIX_LAST) begin
                            state_d = ST_DRAIN;
                        end else begin
                            pix_d = pix_q + PW'(1);
                        end
                    end else begin
                        kern_d = kern_q + AW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Last word leaves with nothing behind it in the buffer or the ROM.
                if (!inflight_q && (occ_q == 2'd1) && pop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output buffer: buf0 is always the head; simultaneous push and pop allowed.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = rom_q;
                else               buf1_d = rom_q;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = rom_q;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = rom_q;
                end
            end
            default: ;
        endcase
    end

    // State registers; reset discards any word still returning from the ROM.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= ST_IDLE;
            kern_q     <= '0;
            pix_q      <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            kern_q     <= kern_d;
            pix_q      <= pix_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            done_q     <= done_d;
        end
    end

    // The credit rule must make a push into a full buffer impossible.
    a_no_overflow: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
        !(push && !pop && (occ_q == 2'd2)));

    // Output assignments.
    always_comb begin
        ap_idle        = (state_q == ST_IDLE);
        ap_done        = done_q;
        rom_ce         = issue;
        rom_address    = kern_q;
        output_V_din   = buf0_q;
        output_V_write = pop;
    end

endmodule

// File: doc/bias_stream_ctrl.md
Name: bias_stream_ctrl

Overview:
Sequencer that streams a layer's bias coefficients from a single-port, 1-cycle-latency bias ROM into an AP-FIFO-style output stream. For each frame it emits all KERNELS biases in address order, once per output pixel, for PIXELS pixels. It absorbs downstream backpressure with a 2-entry output buffer and ROM read credits, so no word is lost or duplicated. It has an ap_start/ap_done/ap_idle control interface and sits between the layer controller and the bias adder.

Parameters:
KERNELS, 16, number of bias words per pixel (ROM depth); must be >= 1
PIXELS, 64, number of output pixels per frame; must be >= 1
DATA_WIDTH, 16, coefficient width

Ports:
ap_clk  in  1  clock; all state updates on the rising edge
ap_rst_n  in  1  asynchronous active-low reset
ap_start  in  1  frame start request; sampled only in IDLE
ap_done  out  1  one-cycle pulse when the last word of the frame has been written
ap_idle  out  1  high while in IDLE
rom_address  out  max(1,$clog2(KERNELS))  bias ROM read address
rom_ce  out  1  ROM read enable
rom_q  in  DATA_WIDTH  ROM data, valid the cycle after rom_ce
output_V_din  out  DATA_WIDTH  stream data; always the buffer head
output_V_full_n  in  1  downstream can accept a word
output_V_write  out  1  transfer strobe = buffer non-empty AND output_V_full_n

Behaviour:
- Reset (asynchronous, any state): state=IDLE, counters=0, buffer empty, in-flight flag=0. Outputs: ap_done=0, ap_idle=1, rom_ce=0, rom_address=0, output_V_write=0, output_V_din=0.
- States: IDLE, RUN, DRAIN.
- IDLE: ap_idle=1. If ap_start=1 at an edge, go to RUN and clear kern_cnt and pix_cnt.
- RUN: assert rom_ce with rom_address=kern_cnt when a credit is available. Credit exists when (occupancy + inflight - pop) <= 1, where pop = output_V_write this cycle.
- On each issue: kern_cnt increments. When kern_cnt reaches KERNELS-1, it wraps to 0 and pix_cnt increments. Issuing kern=KERNELS-1 with pix=PIXELS-1 moves the state to DRAIN.
- inflight is set on the edge that ends an issue cycle. In the following cycle rom_q is pushed into the buffer and inflight clears, unless that cycle issues again.
- DRAIN: rom_ce=0. When the buffer is empty, inflight=0, and the final pop happens, assert ap_done for exactly one cycle (the cycle after the final write) and return to IDLE.
- Buffer: 2-entry FIFO. Push and pop in the same cycle are both honoured. Push into a full buffer never occurs because the credit rule prevents it; assert this in simulation.
- output_V_write depends combinationally on output_V_full_n. With full_n=0 it is 0 and din holds stable.
- Latency: with ap_start sampled at edge E0, rom_ce is high in the cycle after E0, and the first output_V_write occurs 3 cycles after E0 if full_n=1.
- Throughput: 1 word/cycle sustained while full_n=1. A frame takes KERNELS*PIXELS + 3 cycles from start edge to ap_done.
- ap_start while in RUN or DRAIN is ignored; no queuing.
- After full_n stalls, issue resumes in the cycle full_n returns high. Order is preserved exactly.
- Reset mid-frame abandons the frame. Any ROM data in flight is discarded; the next frame restarts at address 0.
- Word count per frame is exactly KERNELS*PIXELS. The stream sequence is rom[0..KERNELS-1] repeated PIXELS times.

Test Plan:
- KERNELS=4, PIXELS=2, ROM={10,11,12,13}, full_n=1, start pulse -> writes 10,11,12,13,10,11,12,13 on 8 consecutive cycles, first at start+3; ap_done one cycle after last write; ap_idle high again.
- Same config, full_n=0 for 5 cycles after the 3rd write -> write=0 and din=13 held; rom_ce drops once the buffer is full; resumes to give the identical 8-word sequence with no loss or duplicates.
- Random full_n (50%) with KERNELS=16, PIXELS=64 -> scoreboard sees 1024 words, sequence rom[i mod 16]; exactly one ap_done.
- ap_start held high during RUN -> exactly one frame; a second frame starts only from IDLE. Back-to-back frames give 2x the sequence.
- ap_rst_n low for 1 cycle after the 5th write -> all outputs return to reset values immediately; a new start yields a full sequence from rom[0].
- KERNELS=1, PIXELS=1, ROM={0x7FFF} -> single write of 0x7FFF at start+3, ap_done the next cycle.
